// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART TX arbiter
// Purpose: FSM state encoding and default timing constants used by uart_tx_arbiter.
// Ports: none (package).
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   localparam int CLKS_PER_BIT_DEF = 1085;
   localparam int TIMEOUT_CLKS_DEF = 12000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Purpose: picks the first asserted request searching upward from ptr+1, wrapping.
// Ports:
//   req        in   N_REQ          request vector
//   ptr        in   $clog2(N_REQ)  index of last winner
//   gnt_onehot out  N_REQ          one-hot winner (zero when no request)
//   gnt_idx    out  $clog2(N_REQ)  winner index (zero when no request)
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IW-1:0]    gnt_idx
);

   int   idx;
   logic found;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      idx        = 0;
      // Offsets 1..N_REQ put the previous winner last in the search order.
      for (int i = 1; i <= N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!found && req[idx]) begin
            found           = 1'b1;
            gnt_idx         = IW'(idx);
            gnt_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter
// Purpose: arbitrates N_REQ byte producers, latches the winning byte, stretches the
// transmitter enable to two cycles, waits for complete (with watchdog), reports done.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_req, i_data   per-requester byte valid and byte (requester k on [8k+7:8k])
//   o_ack, o_done   one-cycle per-requester pulses: byte latched / byte transmitted
//   o_timeout       one-cycle pulse: transfer aborted by watchdog
//   o_busy          high whenever the FSM is not idle
//   o_grant_id      current/last owner index
//   o_tx_byte, o_tx_en, i_tx_complete  transmitter interface
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
   parameter int TO_W         = 14
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [N_REQ-1:0]           i_req,
   input  logic [8*N_REQ-1:0]         i_data,
   output logic [N_REQ-1:0]           o_ack,
   output logic [N_REQ-1:0]           o_done,
   output logic                       o_timeout,
   output logic                       o_busy,
   output logic [$clog2(N_REQ)-1:0]   o_grant_id,
   output logic [7:0]                 o_tx_byte,
   output logic                       o_tx_en,
   input  logic                       i_tx_complete
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [7:0]        byte_q, byte_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [N_REQ-1:0]  done_q, done_d;
   logic              timeout_q, timeout_d;
   logic              busy_q, busy_d;
   logic              tx_en_q, tx_en_d;
   logic              en_cnt_q, en_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   logic [N_REQ-1:0]  gnt_onehot;
   logic [IW-1:0]     gnt_idx;
   logic [7:0]        data_arr [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign data_arr[k] = i_data[8*k +: 8];
   end

   rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
      .req        (i_req),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      byte_d    = byte_q;
      ack_d     = '0;
      done_d    = '0;
      timeout_d = 1'b0;
      tx_en_d   = tx_en_q;
      en_cnt_d  = en_cnt_q;
      to_cnt_d  = to_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (|i_req) begin
               state_d  = S_START;
               ack_d    = gnt_onehot;
               grant_d  = gnt_idx;
               ptr_d    = gnt_idx;
               byte_d   = data_arr[gnt_idx];
               tx_en_d  = 1'b1;
               en_cnt_d = 1'b0;
            end
         end
         S_START: begin
            // Enable already high for one cycle on entry; hold one more so a
            // two-flop edge detector in the transmitter is guaranteed to see it.
            if (!en_cnt_q) begin
               en_cnt_d = 1'b1;
            end else begin
               tx_en_d  = 1'b0;
               to_cnt_d = '0;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // Complete takes precedence over the watchdog in the same cycle.
            if (i_tx_complete) begin
               done_d[grant_q] = 1'b1;
               state_d         = S_GAP;
            end else if (to_cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_GAP;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= IW'(N_REQ - 1);
         grant_q   <= '0;
         byte_q    <= '0;
         ack_q     <= '0;
         done_q    <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
         tx_en_q   <= 1'b0;
         en_cnt_q  <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         byte_q    <= byte_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
         tx_en_q   <= tx_en_d;
         en_cnt_q  <= en_cnt_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   assign o_ack      = ack_q;
   assign o_done     = done_q;
   assign o_timeout  = timeout_q;
   assign o_busy     = busy_q;
   assign o_grant_id = grant_q;
   assign o_tx_byte  = byte_q;
   assign o_tx_en    = tx_en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int T  = 20;
   localparam int TW = 5;

   logic            clk = 1'b0;
   logic            i_rst_n;
   logic [N-1:0]    i_req;
   logic [8*N-1:0]  i_data;
   logic [N-1:0]    o_ack;
   logic [N-1:0]    o_done;
   logic            o_timeout;
   logic            o_busy;
   logic [1:0]      o_grant_id;
   logic [7:0]      o_tx_byte;
   logic            o_tx_en;
   logic            i_tx_complete;

   typedef struct {
      int         id;
      logic [7:0] b;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CLKS(T), .TO_W(TW)) dut (
      .i_clk         (clk),
      .i_rst_n       (i_rst_n),
      .i_req         (i_req),
      .i_data        (i_data),
      .o_ack         (o_ack),
      .o_done        (o_done),
      .o_timeout     (o_timeout),
      .o_busy        (o_busy),
      .o_grant_id    (o_grant_id),
      .o_tx_byte     (o_tx_byte),
      .o_tx_en       (o_tx_en),
      .i_tx_complete (i_tx_complete)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},     32'(o_ack),      32'h0);
      chk({tag, "_done"},    32'(o_done),     32'h0);
      chk({tag, "_timeout"}, 32'(o_timeout),  32'h0);
      chk({tag, "_busy"},    32'(o_busy),     32'h0);
      chk({tag, "_tx_en"},   32'(o_tx_en),    32'h0);
      chk({tag, "_tx_byte"}, 32'(o_tx_byte),  32'h0);
      chk({tag, "_grant"},   32'(o_grant_id), 32'h0);
   endtask

   task automatic apply_reset();
      i_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      i_rst_n = 1'b1;
   endtask

   task automatic post(input int k, input logic [7:0] b);
      exp_t e;
      i_data[8*k +: 8] = b;
      i_req[k]         = 1'b1;
      e.id = k;
      e.b  = b;
      sb.push_back(e);
   endtask

   // mode: 0 normal complete, 1 watchdog timeout, 2 reset during S_WAIT,
   //       3 stray complete during S_START then normal complete
   task automatic serve(input int mode);
      exp_t e;
      int   n;
      bit   got;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e   = sb.pop_front();
      got = 1'b0;
      n   = 0;
      while (!got && n < 50) begin
         @(negedge clk);
         n++;
         if (o_ack != '0) got = 1'b1;
      end
      chk("ack_seen", 32'(got), 32'd1);
      if (!got) return;
      chk("ack_onehot", 32'(o_ack),      32'd1 << e.id);
      chk("grant_id",   32'(o_grant_id), 32'(e.id));
      chk("tx_byte",    32'(o_tx_byte),  32'(e.b));
      chk("tx_en_1",    32'(o_tx_en),    32'd1);
      chk("busy_start", 32'(o_busy),     32'd1);
      i_req[e.id] = 1'b0;
      if (mode == 3) i_tx_complete = 1'b1;
      @(negedge clk);
      i_tx_complete = 1'b0;
      chk("tx_en_2",    32'(o_tx_en), 32'd1);
      chk("ack_pulse",  32'(o_ack),   32'd0);
      chk("done_early", 32'(o_done),  32'd0);
      @(negedge clk);
      chk("tx_en_off",  32'(o_tx_en), 32'd0);
      chk("busy_wait",  32'(o_busy),  32'd1);
      if (mode == 2) begin
         i_rst_n = 1'b0;
         @(negedge clk);
         i_rst_n = 1'b1;
         chk_all_zero("midreset");
         return;
      end
      if (mode == 1) begin
         n   = 0;
         got = 1'b0;
         while (!got && n < T + 10) begin
            @(negedge clk);
            n++;
            if (o_done != '0) chk("done_in_timeout", 32'(o_done), 32'd0);
            if (o_timeout) got = 1'b1;
         end
         chk("timeout_seen",    32'(got),    32'd1);
         chk("timeout_latency", 32'(n),      32'(T));
         chk("done_on_timeout", 32'(o_done), 32'd0);
      end else begin
         i_tx_complete = 1'b1;
         @(negedge clk);
         i_tx_complete = 1'b0;
         chk("done",      32'(o_done),    32'd1 << e.id);
         chk("timeout_0", 32'(o_timeout), 32'd0);
      end
      chk("busy_gap",  32'(o_busy),    32'd1);
      chk("byte_hold", 32'(o_tx_byte), 32'(e.b));
      @(negedge clk);
      chk("done_pulse",    32'(o_done),    32'd0);
      chk("timeout_pulse", 32'(o_timeout), 32'd0);
      chk("busy_idle",     32'(o_busy),    32'd0);
   endtask

   initial begin
      i_rst_n       = 1'b0;
      i_req         = '0;
      i_data        = '0;
      i_tx_complete = 1'b0;

      apply_reset();

      // single requester
      post(0, 8'h55);
      serve(0);

      // stray complete while idle
      i_tx_complete = 1'b1;
      @(negedge clk);
      i_tx_complete = 1'b0;
      chk("idle_cpl_done", 32'(o_done), 32'd0);
      chk("idle_cpl_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      chk("idle_cpl_done2", 32'(o_done), 32'd0);
      chk("idle_cpl_busy2", 32'(o_busy), 32'd0);

      // round robin from reset pointer
      apply_reset();
      post(0, 8'hA0);
      post(1, 8'hA1);
      post(2, 8'hA2);
      repeat (3) serve(0);
      post(3, 8'hB3);
      post(0, 8'hB0);
      repeat (2) serve(0);

      // watchdog, then a normal transfer
      post(1, 8'hC1);
      serve(1);
      post(2, 8'hC2);
      serve(0);

      // reset mid-transfer, then pointer back at requester 0 priority
      post(3, 8'hD3);
      serve(2);
      post(1, 8'hE1);
      post(2, 8'hE2);
      serve(0);
      serve(0);

      // stray complete during S_START
      post(0, 8'hF0);
      serve(3);

      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
